i2c_write_arbiter: RTL and testbench
====================================

// Module: i2c_write_arbiter
// PURPOSE
//   Shares one i2c_fifo_master between NUM_REQ requesters. Round-robin grants the write
//   path, forwards (addr,data) byte writes as single-cycle start pulses into the master
//   FIFO, honours fifo_full backpressure and keeps each granted burst contiguous.
//   Sits on logic_clk_in between client blocks and i2c_fifo_master (start/addr_in/data_in).
// PARAMETERS
//   NUM_REQ    4   number of requesters (2..8)
//   MAX_BURST  4   max bytes accepted per grant before forced rotation (1..16)
// PORTS
//   logic_clk_in  in   1          single system clock, all logic on rising edge
//   reset_in      in   1          synchronous, active-low reset
//   req_valid     in   NUM_REQ    requester i has a byte pending
//   req_addr      in   NUM_REQ*7  requester i address at [7i+6:7i]
//   req_data      in   NUM_REQ*8  requester i data at [8i+7:8i]
//   req_last      in   NUM_REQ    current byte of requester i ends its burst
//   req_ready     out  NUM_REQ    one-hot; byte of requester i accepted when valid&ready
//   fifo_full     in   1          from i2c_fifo_master
//   start_out     out  1          one-cycle write strobe to master start
//   addr_out      out  7          to master addr_in, valid with start_out
//   data_out      out  8          to master data_in, valid with start_out
//   grant_out     out  NUM_REQ    one-hot current owner, 0 when idle
//   busy_out      out  1          1 while in GRANT state
// BEHAVIOUR
//   Reset (reset_in=0 at a clock edge): state=IDLE, start_out=0, addr_out=0, data_out=0,
//     grant_out=0, busy_out=0, burst count=0, rr pointer=NUM_REQ-1 (req 0 wins first).
//     Reset mid-burst drops the in-flight burst; no start pulse in the reset cycle or after.
//   FSM: IDLE, GRANT.
//   IDLE: if |req_valid, pick first set bit scanning ptr+1, ptr+2, ... modulo NUM_REQ;
//     next cycle grant_out=one-hot(g), busy_out=1, count=0, state=GRANT. Else stay.
//     req_ready=0 in IDLE.
//   GRANT: req_ready[g] = req_valid[g] & ~fifo_full & ~start_out (combinational);
//     all other req_ready bits 0. At most one accept every 2 cycles so fifo_full
//     always reflects the previous write.
//   Accept (req_valid[g]&req_ready[g]) in cycle N: cycle N+1 start_out=1,
//     addr_out=req_addr[g], data_out=req_data[g]; start_out low otherwise.
//     addr_out/data_out hold last values when start_out=0.
//   Release: on accept with req_last[g]=1 or count==MAX_BURST-1, or whenever
//     req_valid[g]=0 in GRANT: next state IDLE, ptr=g, grant_out=0, count=0.
//     Release on accept still emits that byte's start_out in the following cycle.
//   count increments by 1 per accept, never exceeds MAX_BURST-1.
//   fifo_full=1 during GRANT: hold grant, no accept, count unchanged (no rotation).
//   Latency: req_valid rise in IDLE at N -> grant N+1 -> accept N+1 -> start_out N+2.
//   Simultaneous requests resolved purely by rr pointer; no requester starves:
//     any valid requester is granted within NUM_REQ-1 grants.
//   req_addr/req_data/req_last sampled only on accept; other inputs ignored.
// TESTING
//   1 Reset: hold reset_in=0 3 cycles -> all outputs 0; release, req_valid=0 -> stay IDLE.
//   2 Single: req0 valid addr=7'h55 data=8'hAA last=1 -> grant_out=0001 next cycle,
//     start_out one pulse 2 cycles after request with 55/AA, then IDLE, ptr=0.
//   3 Round-robin: req 0,1,2 valid, last=1 each -> grant order 0,1,2,0; data 8'h01,
//     8'hD3, 8'hAA seen in that order on data_out.
//   4 Burst cap: req1 valid 6 bytes, last=0, MAX_BURST=4 -> 4 start pulses, 1 idle gap
//     each, rotation to req2 if valid else req1 re-granted; remaining 2 bytes follow.
//   5 Backpressure: fifo_full=1 during GRANT for 10 cycles -> no req_ready, no start_out,
//     grant held; fifo_full=0 -> accept next cycle, pulse the cycle after.
//   6 Reset mid-burst: reset_in=0 the cycle after an accept -> no start_out, all outputs 0.

Source files
------------

// File: rtl/i2c_write_arbiter.sv
// i2c_write_arbiter: round-robin write arbiter in front of i2c_fifo_master.
// Ports: logic_clk_in/reset_in (sync, active-low); per-requester req_valid,
//   req_addr (7b each), req_data (8b each), req_last, req_ready (one-hot);
//   fifo_full from master; start_out/addr_out/data_out to master;
//   grant_out (one-hot owner, 0 when idle), busy_out (owner present).
module i2c_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                 logic_clk_in,
  input  logic                 reset_in,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*7-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 fifo_full,
  output logic                 start_out,
  output logic [6:0]           addr_out,
  output logic [7:0]           data_out,
  output logic [NUM_REQ-1:0]   grant_out,
  output logic                 busy_out
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state, state_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [IW-1:0] gidx, gidx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          start_q, start_n;
  logic [6:0]    addr_n;
  logic [7:0]    data_n;

  logic          pick_hit;
  logic [IW-1:0] pick;
  logic          g_valid;
  logic          g_last;
  logic [6:0]    g_addr;
  logic [7:0]    g_data;
  logic          accept;

  // Scan ptr+NUM_REQ down to ptr+1 so the lowest offset is written last
  // and therefore wins.
  always_comb begin
    int idx;
    idx      = 0;
    pick_hit = 1'b0;
    pick     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        pick_hit = 1'b1;
        pick     = IW'(idx);
      end
    end
  end

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_addr  = '0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx == IW'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_addr  = req_addr[7*i +: 7];
        g_data  = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    gidx_n    = gidx;
    cnt_n     = cnt;
    start_n   = 1'b0;
    addr_n    = addr_out;
    data_n    = data_out;
    req_ready = '0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_hit) begin
          state_n = GRANT;
          gidx_n  = pick;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        // The ~start_q term spaces accepts two cycles apart so that
        // fifo_full already reflects the previous write.
        accept          = g_valid & ~fifo_full & ~start_q;
        req_ready[gidx] = accept;
        if (accept) begin
          start_n = 1'b1;
          addr_n  = g_addr;
          data_n  = g_data;
          if (g_last || cnt == CNT_MAX) begin
            state_n = IDLE;
            ptr_n   = gidx;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end else if (!g_valid) begin
          state_n = IDLE;
          ptr_n   = gidx;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge logic_clk_in) begin
    if (!reset_in) begin
      state    <= IDLE;
      ptr      <= PTR_RST;
      gidx     <= '0;
      cnt      <= '0;
      start_q  <= 1'b0;
      addr_out <= '0;
      data_out <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      gidx     <= gidx_n;
      cnt      <= cnt_n;
      start_q  <= start_n;
      addr_out <= addr_n;
      data_out <= data_n;
    end
  end

  // A reset arriving right after an accept must swallow the pending strobe.
  assign start_out = start_q & reset_in;
  assign busy_out  = (state == GRANT);

  always_comb begin
    grant_out = '0;
    if (state == GRANT) grant_out[gidx] = 1'b1;
  end

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// tb_i2c_write_arbiter: directed bench with a transaction-level model
// of the arbiter and per-cycle output comparison.
module tb_i2c_write_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*7-1:0] req_addr;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           start_out;
  logic [6:0]     addr_out;
  logic [7:0]     data_out;
  logic [N-1:0]   grant_out;
  logic           busy_out;

  i2c_write_arbiter #(
    .NUM_REQ  (N),
    .MAX_BURST(MB)
  ) dut (
    .logic_clk_in(clk),
    .reset_in    (rst_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .start_out   (start_out),
    .addr_out    (addr_out),
    .data_out    (data_out),
    .grant_out   (grant_out),
    .busy_out    (busy_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Pending bytes per requester: {last, addr[6:0], data[7:0]}.
  logic [15:0] q [N][$];

  // Model: owner index (-1 = nobody), pointer, bytes taken this burst,
  // whether a write was accepted last cycle, last forwarded addr/data.
  int         m_owner = -1;
  int         m_ptr   = N - 1;
  int         m_cnt   = 0;
  logic       m_start = 1'b0;
  logic [6:0] m_addr  = '0;
  logic [7:0] m_data  = '0;

  int         p_cyc  [$];
  logic [6:0] p_addr [$];
  logic [7:0] p_data [$];
  int         g_log  [$];
  logic [N-1:0] prev_grant = '0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive_heads();
    logic [15:0] e;
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        e = q[i][0];
        req_valid[i]       = 1'b1;
        req_last[i]        = e[15];
        req_addr[7*i +: 7] = e[14:8];
        req_data[8*i +: 8] = e[7:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic push(int r, logic [6:0] a, logic [7:0] d, logic l);
    q[r].push_back({l, a, d});
  endtask

  task automatic clear_logs();
    p_cyc.delete();
    p_addr.delete();
    p_data.delete();
    g_log.delete();
  endtask

  // Model step on each rising edge, then re-present requester heads.
  always @(posedge clk) begin
    int          g;
    int          idx;
    logic        acc;
    logic [15:0] e;
    cyc++;
    if (!rst_n) begin
      m_owner = -1;
      m_ptr   = N - 1;
      m_cnt   = 0;
      m_start = 1'b0;
      m_addr  = '0;
      m_data  = '0;
    end else if (m_owner < 0) begin
      m_start = 1'b0;
      for (int k = 1; k <= N; k++) begin
        idx = (m_ptr + k) % N;
        if (req_valid[idx] && m_owner < 0) begin
          m_owner = idx;
          m_cnt   = 0;
        end
      end
    end else begin
      g   = m_owner;
      acc = req_valid[g] && !fifo_full && !m_start;
      m_start = acc;
      if (acc) begin
        e = q[g].pop_front();
        m_addr = e[14:8];
        m_data = e[7:0];
        m_cnt++;
        if (e[15] || m_cnt == MB) begin
          m_ptr   = g;
          m_owner = -1;
          m_cnt   = 0;
        end
      end else if (!req_valid[g]) begin
        m_ptr   = g;
        m_owner = -1;
        m_cnt   = 0;
      end
    end
    #1 drive_heads();
  end

  // Compare process: every falling edge once reset has been applied.
  always @(negedge clk) begin
    logic [N-1:0] eg;
    logic [N-1:0] er;
    eg = '0;
    er = '0;
    if (cyc > 0) begin
      if (m_owner >= 0) begin
        eg[m_owner] = 1'b1;
        er[m_owner] = req_valid[m_owner] && !fifo_full && !m_start;
      end
      check("grant_out", 32'(grant_out), 32'(eg));
      check("req_ready", 32'(req_ready), 32'(er));
      check("busy_out", 32'(busy_out), 32'(m_owner >= 0));
      check("start_out", 32'(start_out), 32'(m_start && rst_n));
      check("addr_out", 32'(addr_out), 32'(m_addr));
      check("data_out", 32'(data_out), 32'(m_data));
      if (start_out === 1'b1) begin
        p_cyc.push_back(cyc);
        p_addr.push_back(addr_out);
        p_data.push_back(data_out);
      end
      if (prev_grant == '0 && grant_out != '0) begin
        for (int i = 0; i < N; i++)
          if (grant_out[i]) g_log.push_back(i);
      end
      prev_grant = grant_out;
    end
  end

  initial begin
    int t0;
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    req_last  = '0;

    // Reset held three cycles.
    repeat (3) @(posedge clk);
    #2;
    check("rst_grant", 32'(grant_out), 32'h0);
    check("rst_busy", 32'(busy_out), 32'h0);
    check("rst_start", 32'(start_out), 32'h0);
    check("rst_addr", 32'(addr_out), 32'h0);
    check("rst_data", 32'(data_out), 32'h0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("idle_busy", 32'(busy_out), 32'h0);

    // Single byte from requester 0.
    clear_logs();
    t0 = cyc;
    push(0, 7'h55, 8'hAA, 1'b1);
    drive_heads();
    @(posedge clk);
    #2;
    check("single_grant", 32'(grant_out), 32'h1);
    repeat (5) @(posedge clk);
    #2;
    check("single_npulse", 32'(p_cyc.size()), 32'd1);
    if (p_cyc.size() == 1) begin
      check("single_lat", 32'(p_cyc[0] - t0), 32'd2);
      check("single_addr", 32'(p_addr[0]), 32'h55);
      check("single_data", 32'(p_data[0]), 32'hAA);
    end
    check("single_idle", 32'(busy_out), 32'h0);

    // Round robin from a fresh pointer; requester 0 has two bytes.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    clear_logs();
    push(0, 7'h10, 8'h01, 1'b1);
    push(0, 7'h11, 8'h5A, 1'b1);
    push(1, 7'h21, 8'hD3, 1'b1);
    push(2, 7'h32, 8'hAA, 1'b1);
    drive_heads();
    repeat (20) @(posedge clk);
    #2;
    check("rr_ngrant", 32'(g_log.size()), 32'd4);
    check("rr_npulse", 32'(p_data.size()), 32'd4);
    if (g_log.size() == 4 && p_data.size() == 4) begin
      check("rr_g0", 32'(g_log[0]), 32'd0);
      check("rr_g1", 32'(g_log[1]), 32'd1);
      check("rr_g2", 32'(g_log[2]), 32'd2);
      check("rr_g3", 32'(g_log[3]), 32'd0);
      check("rr_d0", 32'(p_data[0]), 32'h01);
      check("rr_d1", 32'(p_data[1]), 32'hD3);
      check("rr_d2", 32'(p_data[2]), 32'hAA);
      check("rr_d3", 32'(p_data[3]), 32'h5A);
    end

    // Burst cap: six bytes from req1 rotate to req2 after four.
    clear_logs();
    for (int i = 0; i < 6; i++)
      push(1, 7'(8'h40 + i), 8'(8'h80 + i), 1'b0);
    push(2, 7'h2A, 8'hC2, 1'b1);
    drive_heads();
    repeat (30) @(posedge clk);
    #2;
    check("cap_ngrant", 32'(g_log.size()), 32'd3);
    check("cap_npulse", 32'(p_data.size()), 32'd7);
    if (g_log.size() == 3 && p_data.size() == 7) begin
      check("cap_g0", 32'(g_log[0]), 32'd1);
      check("cap_g1", 32'(g_log[1]), 32'd2);
      check("cap_g2", 32'(g_log[2]), 32'd1);
      check("cap_d3", 32'(p_data[3]), 32'h83);
      check("cap_d4", 32'(p_data[4]), 32'hC2);
      check("cap_d5", 32'(p_data[5]), 32'h84);
      check("cap_d6", 32'(p_data[6]), 32'h85);
      for (int i = 1; i < 7; i++)
        check("cap_gap", 32'(p_cyc[i] - p_cyc[i-1]), 32'd2);
    end

    // Backpressure: grant held for ten cycles with fifo_full high.
    clear_logs();
    fifo_full = 1'b1;
    push(3, 7'h3C, 8'hE7, 1'b1);
    drive_heads();
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      #2;
      check("bp_grant", 32'(grant_out), 32'h8);
      check("bp_ready", 32'(req_ready), 32'h0);
      check("bp_start", 32'(start_out), 32'h0);
      @(posedge clk);
    end
    #2;
    fifo_full = 1'b0;
    t0 = cyc;
    #1;
    check("bp_accept", 32'(req_ready), 32'h8);
    repeat (4) @(posedge clk);
    #2;
    check("bp_npulse", 32'(p_cyc.size()), 32'd1);
    if (p_cyc.size() == 1) begin
      check("bp_lat", 32'(p_cyc[0] - t0), 32'd1);
      check("bp_data", 32'(p_data[0]), 32'hE7);
    end

    // Reset the cycle after an accept: the pending strobe is dropped.
    clear_logs();
    push(0, 7'h11, 8'h66, 1'b0);
    push(0, 7'h12, 8'h67, 1'b0);
    push(0, 7'h13, 8'h68, 1'b1);
    drive_heads();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) q[i].delete();
    drive_heads();
    #1;
    check("mid_rst_start", 32'(start_out), 32'h0);
    repeat (2) @(posedge clk);
    #2;
    check("mid_rst_grant", 32'(grant_out), 32'h0);
    check("mid_rst_busy", 32'(busy_out), 32'h0);
    check("mid_rst_addr", 32'(addr_out), 32'h0);
    check("mid_rst_data", 32'(data_out), 32'h0);
    check("mid_rst_npulse", 32'(p_cyc.size()), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check("post_rst_npulse", 32'(p_cyc.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
